serial_magnitude_comparator: RTL and testbench
==============================================

Name: serial_magnitude_comparator

Overview:
- Multi-cycle magnitude comparator for two WIDTH-bit operands, scanned one bit per cycle, MSB first.
- Each step uses a one-bit compare cell; the per-bit 3-bit codes are folded into a running relation.
- Result uses the same 3-bit relation code as the single-bit compare cell.
- Sits between operand-producing datapath logic and control logic; valid/ready on both sides.

Parameters:
- WIDTH, 8, operand width in bits; legal range 1..32.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  operand pair offered
- in_ready  output  1  block can accept operands
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- signed_cmp  input  1  1 = two's-complement compare, 0 = unsigned; sampled with a/b
- out_valid  output  1  result available
- out_ready  input  1  consumer accepts result
- y  output  3  {gt, eq, lt}: 3'b100 A>B, 3'b010 A==B, 3'b001 A<B
- busy  output  1  high in SCAN or DONE

Behaviour:
- Reset is synchronous, active-low, and the only reset.
  - State goes to IDLE.
  - in_ready=1, out_valid=0, y=3'b000, busy=0.
  - Internal shift registers, bit counter and relation register are cleared.
- y is driven 3'b000 whenever out_valid=0. It is never X.
- FSM states: IDLE, SCAN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid && in_ready: latch a, b and signed_cmp; set relation to EQ; load counter with WIDTH-1; go to SCAN.
- SCAN:
  - in_ready=0.
  - Each cycle, compare the current MSB pair and update relation, only while relation is still EQ. The first differing bit decides the result.
  - Shift both operands left by 1; decrement the counter.
  - In the cycle that processes counter==0, go to DONE.
- Signed rule: at the bit index WIDTH-1 step only, when signed_cmp=1 and the bits differ, invert the gt/lt decision (a set sign bit means the smaller value).
- DONE:
  - out_valid=1 and y=relation, held stable until out_ready.
  - On out_ready: go to IDLE.
  - in_ready does not rise in the same cycle (one-cycle bubble between transactions).
- Latency, accept edge to out_valid high: WIDTH+1 cycles. With the optional feature enabled: see below.
- Throughput: one compare every WIDTH+2 cycles minimum.
- Boundaries:
  - WIDTH=1: a single SCAN cycle; the sign rule applies to that bit.
  - in_valid while not in IDLE is ignored; operands are not latched.
  - out_ready while not in DONE has no effect.
  - Changing a, b or signed_cmp after acceptance does not affect the result.
  - rst_n low mid-SCAN or in DONE abandons the transaction. Next cycle is IDLE; no result is emitted.
- Widths: the counter is $clog2(WIDTH) bits, with a minimum of 1 bit.

Optional Feature:
- Macro: SERCMP_EARLY_EXIT_EN.
- Defined:
  - SCAN goes to DONE in the cycle the first differing bit is processed.
  - Latency is k+1 cycles, where k = 1 + (number of equal leading bits).
  - Equal operands still take WIDTH+1 cycles.
- Undefined: always WIDTH scan cycles, giving a fixed latency of WIDTH+1.
- The result value is identical in both builds.

Decomposition:
- Shared package serial_cmp_pkg:
  - Relation code localparams REL_GT=3'b100, REL_EQ=3'b010, REL_LT=3'b001.
  - FSM state encoding: IDLE=2'd0, SCAN=2'd1, DONE=2'd2.
- One sub-module: bit_compare_cell.
  - Purely combinational: inputs a_bit, b_bit; output y[2:0] in the same code.
  - Instantiated once for the MSB pair.
- The fold and sign-inversion logic stays in the top module.

Test Plan:
1. Unsigned, WIDTH=8: a=8'hA5, b=8'h5A, signed_cmp=0 -> y=3'b100 exactly 9 cycles after accept; with EARLY_EXIT, 2 cycles.
2. Signed, WIDTH=8: a=8'hFF (-1), b=8'h01, signed_cmp=1 -> y=3'b001. Same operands with signed_cmp=0 -> y=3'b100.
3. Equal: a=b=8'h3C -> y=3'b010 after 9 cycles in both builds.
4. Backpressure: hold out_ready=0 for 5 cycles after out_valid -> y and out_valid stable throughout, in_ready=0; a new in_valid is ignored. Release -> in_ready=1 one cycle later.
5. Reset mid-operation: rst_n=0 on the 3rd SCAN cycle of a=8'h80, b=8'h00 -> next cycle IDLE, out_valid=0, y=3'b000. The next transaction a=8'h01, b=8'h02 gives y=3'b001.
6. WIDTH=1: all four (a,b) pairs with signed_cmp 0 and 1 -> correct codes. For example, a=1, b=0, signed -> 3'b001 (-1 < 0), 2-cycle latency.

Source files
------------

// File: rtl/serial_cmp_pkg.sv
// Shared relation codes, FSM encoding and helpers for the serial magnitude comparator.
package serial_cmp_pkg;

  localparam logic [2:0] REL_GT = 3'b100;
  localparam logic [2:0] REL_EQ = 3'b010;
  localparam logic [2:0] REL_LT = 3'b001;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  // Swapping gt and lt leaves eq untouched, so it is safe to apply to any code.
  function automatic logic [2:0] swap_rel(input logic [2:0] rel);
    return {rel[0], rel[1], rel[2]};
  endfunction

endpackage

// File: rtl/bit_compare_cell.sv
// One-bit magnitude compare cell producing the {gt, eq, lt} relation code.
module bit_compare_cell
  import serial_cmp_pkg::*;
(
  input  logic       a_bit,
  input  logic       b_bit,
  output logic [2:0] y
);

  always_comb begin
    y = REL_EQ;
    if (a_bit && !b_bit) begin
      y = REL_GT;
    end else if (!a_bit && b_bit) begin
      y = REL_LT;
    end
  end

endmodule

// File: rtl/serial_magnitude_comparator.sv
// MSB-first serial magnitude comparator (unsigned or two's complement) with valid/ready handshakes.
// Optional build macro SERCMP_EARLY_EXIT_EN ends the scan at the first differing bit.
module serial_magnitude_comparator
  import serial_cmp_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             signed_cmp,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2:0]       y,
  output logic             busy
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(WIDTH - 1);

  state_t           state_reg;
  logic [WIDTH-1:0] a_sh_reg;
  logic [WIDTH-1:0] b_sh_reg;
  logic             signed_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [2:0]       rel_reg;
  logic             in_ready_reg;
  logic             out_valid_reg;
  logic             busy_reg;
  logic [2:0]       y_reg;

  logic [2:0]       cell_y;
  logic [2:0]       rel_next;
  logic             scan_last;

  bit_compare_cell u_cell (
    .a_bit (a_sh_reg[WIDTH-1]),
    .b_bit (b_sh_reg[WIDTH-1]),
    .y     (cell_y)
  );

  // Only the first differing bit decides; the sign bit is always the first one scanned.
  always_comb begin
    rel_next = rel_reg;
    if (rel_reg == REL_EQ) begin
      rel_next = cell_y;
      if (signed_reg && (cnt_reg == CNT_TOP)) begin
        rel_next = swap_rel(cell_y);
      end
    end
  end

`ifdef SERCMP_EARLY_EXIT_EN
  assign scan_last = (cnt_reg == '0) || (rel_next != REL_EQ);
`else
  assign scan_last = (cnt_reg == '0);
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      a_sh_reg      <= '0;
      b_sh_reg      <= '0;
      signed_reg    <= 1'b0;
      cnt_reg       <= '0;
      rel_reg       <= '0;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
      busy_reg      <= 1'b0;
      y_reg         <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid && in_ready_reg) begin
            a_sh_reg     <= a;
            b_sh_reg     <= b;
            signed_reg   <= signed_cmp;
            rel_reg      <= REL_EQ;
            cnt_reg      <= CNT_TOP;
            in_ready_reg <= 1'b0;
            busy_reg     <= 1'b1;
            state_reg    <= SCAN;
          end
        end
        SCAN: begin
          rel_reg  <= rel_next;
          a_sh_reg <= a_sh_reg << 1;
          b_sh_reg <= b_sh_reg << 1;
          cnt_reg  <= cnt_reg - 1'b1;
          if (scan_last) begin
            out_valid_reg <= 1'b1;
            y_reg         <= rel_next;
            state_reg     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_reg <= 1'b0;
            y_reg         <= '0;
            busy_reg      <= 1'b0;
            in_ready_reg  <= 1'b1;
            state_reg     <= IDLE;
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign y         = y_reg;
  assign busy      = busy_reg;

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Directed self-checking bench: WIDTH=8 and WIDTH=1 instances, latency counted from the accept edge.
module tb_serial_magnitude_comparator;

  localparam logic [2:0] GT = 3'b100;
  localparam logic [2:0] EQ = 3'b010;
  localparam logic [2:0] LT = 3'b001;

  logic       clk = 1'b0;
  logic       rst_n;

  logic       in_valid8, in_ready8, s8, out_valid8, out_ready8, busy8;
  logic [7:0] a8, b8;
  logic [2:0] y8;

  logic       in_valid1, in_ready1, s1, out_valid1, out_ready1, busy1;
  logic [0:0] a1, b1;
  logic [2:0] y1;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  serial_magnitude_comparator #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .signed_cmp(s8), .out_valid(out_valid8),
    .out_ready(out_ready8), .y(y8), .busy(busy8)
  );

  serial_magnitude_comparator #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a1), .b(b1), .signed_cmp(s1), .out_valid(out_valid1),
    .out_ready(out_ready1), .y(y1), .busy(busy1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Latency counts the accept edge as cycle 1; the full scan of WIDTH=8 gives 9.
  task automatic run8(input string tag, input logic [7:0] a, input logic [7:0] b, input logic s,
                      input logic [2:0] exp_y, input int lat_early, input int hold);
    int lat;
    int exp_lat;
    logic [2:0] y_seen;
`ifdef SERCMP_EARLY_EXIT_EN
    exp_lat = lat_early;
`else
    exp_lat = 9;
`endif
    a8 = a; b8 = b; s8 = s; in_valid8 = 1'b1;
    check($sformatf("%s in_ready_idle", tag), 32'(in_ready8), 32'd1);
    @(posedge clk); #1;
    in_valid8 = 1'b0; a8 = ~a; b8 = ~b; s8 = ~s;
    check($sformatf("%s busy_scan", tag), 32'(busy8), 32'd1);
    check($sformatf("%s in_ready_scan", tag), 32'(in_ready8), 32'd0);
    lat = 1;
    while (!out_valid8 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    y_seen = y8;
    check($sformatf("%s latency", tag), 32'(lat), 32'(exp_lat));
    check($sformatf("%s y", tag), 32'(y8), 32'(exp_y));
    for (int h = 0; h < hold; h++) begin
      in_valid8 = 1'b1; a8 = 8'h00; b8 = 8'hFF; s8 = 1'b0;
      @(posedge clk); #1;
      check($sformatf("%s hold%0d out_valid", tag, h), 32'(out_valid8), 32'd1);
      check($sformatf("%s hold%0d y", tag, h), 32'(y8), 32'(exp_y));
      check($sformatf("%s hold%0d in_ready", tag, h), 32'(in_ready8), 32'd0);
    end
    in_valid8 = 1'b0; out_ready8 = 1'b1;
    @(posedge clk); #1;
    out_ready8 = 1'b0;
    check($sformatf("%s out_valid_clr", tag), 32'(out_valid8), 32'd0);
    check($sformatf("%s y_clr", tag), 32'(y8), 32'd0);
    check($sformatf("%s in_ready_back", tag), 32'(in_ready8), 32'd1);
    check($sformatf("%s busy_clr", tag), 32'(busy8), 32'd0);
    $display("txn w8 %s a=%h b=%h signed=%0d y=%b lat=%0d", tag, a, b, s, y_seen, lat);
  endtask

  task automatic run1(input string tag, input logic a, input logic b, input logic s,
                      input logic [2:0] exp_y);
    int lat;
    logic [2:0] y_seen;
    a1 = a; b1 = b; s1 = s; in_valid1 = 1'b1;
    @(posedge clk); #1;
    in_valid1 = 1'b0; a1 = ~a; b1 = ~b; s1 = ~s;
    lat = 1;
    while (!out_valid1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    y_seen = y1;
    check($sformatf("%s latency", tag), 32'(lat), 32'd2);
    check($sformatf("%s y", tag), 32'(y1), 32'(exp_y));
    out_ready1 = 1'b1;
    @(posedge clk); #1;
    out_ready1 = 1'b0;
    check($sformatf("%s out_valid_clr", tag), 32'(out_valid1), 32'd0);
    $display("txn w1 %s a=%0d b=%0d signed=%0d y=%b lat=%0d", tag, a, b, s, y_seen, lat);
  endtask

  // Indexed by {signed, a, b}.
  logic [2:0] exp1 [8] = '{EQ, LT, GT, EQ, EQ, GT, LT, EQ};

  initial begin
    rst_n = 1'b0;
    in_valid8 = 1'b0; out_ready8 = 1'b0; a8 = '0; b8 = '0; s8 = 1'b0;
    in_valid1 = 1'b0; out_ready1 = 1'b0; a1 = '0; b1 = '0; s1 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("reset in_ready", 32'(in_ready8), 32'd1);
    check("reset out_valid", 32'(out_valid8), 32'd0);
    check("reset y", 32'(y8), 32'd0);
    check("reset busy", 32'(busy8), 32'd0);
    check("reset w1 in_ready", 32'(in_ready1), 32'd1);
    check("reset w1 y", 32'(y1), 32'd0);

    run8("unsigned_a5_5a", 8'hA5, 8'h5A, 1'b0, GT, 2, 0);
    run8("signed_ff_01",   8'hFF, 8'h01, 1'b1, LT, 2, 0);
    run8("unsigned_ff_01", 8'hFF, 8'h01, 1'b0, GT, 2, 0);
    run8("equal_3c",       8'h3C, 8'h3C, 1'b0, EQ, 9, 0);
    run8("signed_80_7f",   8'h80, 8'h7F, 1'b1, LT, 2, 0);
    run8("signed_fe_fd",   8'hFE, 8'hFD, 1'b1, GT, 8, 0);
    run8("backpressure",   8'h10, 8'h20, 1'b0, LT, 4, 5);

    // Abort a transaction with reset during its third scan cycle.
    a8 = 8'h80; b8 = 8'h00; s8 = 1'b0; in_valid8 = 1'b1;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("abort out_valid", 32'(out_valid8), 32'd0);
    check("abort y", 32'(y8), 32'd0);
    check("abort in_ready", 32'(in_ready8), 32'd1);
    check("abort busy", 32'(busy8), 32'd0);
    $display("txn w8 abort a=80 b=00 reset mid-scan");
    run8("after_abort_01_02", 8'h01, 8'h02, 1'b0, LT, 8, 0);

    for (int i = 0; i < 8; i++) begin
      logic [2:0] idx;
      idx = 3'(i);
      run1($sformatf("w1_s%0d_a%0d_b%0d", idx[2], idx[1], idx[0]), idx[1], idx[0], idx[2], exp1[i]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
